uart_rx: RTL

- UART receiver; the counterpart of the team's UART transmitter. Recovers 8N1-style frames (configurable width) from an asynchronous serial line.
- Uses internal oversampling by a clock-count per bit and presents each received byte with a one-cycle valid strobe.
- Sits between the pad-side serial input and the core-side consumer. The consumer has no backpressure.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART frame-format definitions for the receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Count at which the middle of the start bit is reached.
    function automatic int half_bit_count(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus a third flop for falling-edge detection.
// All flops reset to 1 so an idle-high line never reports a false edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], i_async};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q[1];
    assign o_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled, LSB first, one stop bit, one-cycle result strobes.
// Defining UART_RX_PARITY_EN adds a parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to mid start bit; a high there is a glitch
// DATA   | sampling DATA_WIDTH bits at mid-bit, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then strobing the result
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_serial,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_frame_error,
    output logic                  o_parity_error,
    output logic                  o_busy
);

`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(half_bit_count(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_rx_serial),
        .o_sync  (rx_s),
        .o_fall  (rx_fall)
    );

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  perr_q, perr_d;
    logic                  busy_q, busy_d;
    logic                  par_mismatch;

    assign par_mismatch = PARITY_EN & (((^shift_q) ^ PAR_ODD) != par_bit_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Errored frames still publish their data for diagnostics.
                if (cnt_q == BIT_TC) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    ferr_d  = ~rx_s;
                    perr_d  = par_mismatch;
                    valid_d = rx_s & ~par_mismatch;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_rx_data      = data_q;
    assign o_rx_valid     = valid_q;
    assign o_frame_error  = ferr_q;
    assign o_parity_error = perr_q;
    assign o_busy         = busy_q;

endmodule
